count60_down_timer: RTL and testbench
=====================================

Name: count60_down_timer

Overview:
- Loadable mm:ss BCD countdown timer (00:00 to 59:59). It is the down-counting counterpart to the team's mod-60 BCD up-counters.
- Counts down one second per `tick` pulse.
- Pulses `bout` on reaching 00:00, then stops or auto-reloads.
- Sits beside the clock/stopwatch counters and shares their tick source and BCD display path.

Parameters:
- AUTO_RELOAD, 0: 1 means reload the last loaded value on expiry and keep running; 0 means stop in DONE.
- MAX_MIN, 8'h59: highest accepted minutes value (BCD). Loads with minutes above this are rejected.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous active-low reset.
- tick, input, 1: one-cycle count enable (1 Hz strobe); ignored unless state is RUN.
- ld, input, 1: one-cycle load strobe.
- ld_val, input, 16: BCD load value {m_tens, m_ones, s_tens, s_ones}.
- start, input, 1: one-cycle start/resume strobe.
- pause, input, 1: one-cycle pause strobe.
- qout, output, 16: current BCD value {mm, ss}, registered.
- bout, output, 1: borrow/expiry pulse, one cycle.
- busy, output, 1: high while state is RUN.
- err, output, 1: one-cycle pulse for a rejected load or rejected start.

Behaviour:
- Reset (rst=0, asynchronous):
  - qout=16'h0000, reload register=16'h0000, state=IDLE.
  - bout=0, busy=0, err=0.
- States: IDLE, RUN, PAUSE, DONE. `busy` is registered and equals (state==RUN).
- Command priority within one cycle: ld > start > pause > tick. Only the highest-priority command present takes effect.
- ld, any state:
  - Valid value means every nibble ≤ 9, s_tens ≤ 5, and mm ≤ MAX_MIN.
  - Valid: qout and reload register take ld_val next cycle; state becomes IDLE.
  - Invalid: qout, reload register and state are unchanged; err=1 for one cycle.
- start:
  - In IDLE or PAUSE with qout≠0: go to RUN.
  - With qout==0: stay in the current state and pulse err.
  - In RUN: no effect.
  - In DONE: restart only if AUTO_RELOAD=0 path has reloaded; otherwise pulse err and stay in DONE (qout==0).
- pause: RUN→PAUSE. No effect in any other state; no err.
- tick in RUN, decrement qout by one second in BCD:
  - s_ones>0: s_ones-1.
  - Otherwise s_ones=9, and if s_tens>0: s_tens-1.
  - Otherwise s_tens=5 and minutes borrow: m_ones-1, or m_ones=9 with m_tens-1.
  - Example: 10:00 → 09:59.
- Expiry (tick in RUN with qout==16'h0001):
  - qout becomes 16'h0000; bout=1 in the same registered cycle.
  - AUTO_RELOAD=0: state goes to DONE; qout holds 0000; busy drops the same edge.
  - AUTO_RELOAD=1: qout takes the reload register (not 0000) on that edge; state stays RUN; bout=1 for one cycle.
  - AUTO_RELOAD=1 with reload register==0: behave as AUTO_RELOAD=0.
- Latency: qout, bout, busy and err all update on the clk edge that samples the command. No combinational path from inputs to outputs.
- tick outside RUN is ignored; qout is held.
- bout never asserts except at expiry. Loading 0000 does not produce bout.
- Reset asserted mid-count forces the reset values immediately. After release the block waits in IDLE; no bout.

Test Plan:
- Reset, then ld 16'h0003, start, 3 ticks → qout 0002, 0001, 0000; bout high exactly on the cycle qout becomes 0000; busy falls; state DONE; a fourth tick leaves 0000.
- ld 16'h1000, start, 1 tick → qout 16'h0959. Continue from ld 16'h0100, 1 tick → 16'h0059.
- ld 16'h0560 (s_tens=6) and ld 16'h6000 → err pulse each; qout unchanged from the previous value.
- RUN at 00:05, pause, 3 ticks → qout stays 0005. start, 1 tick → 0004.
- Same cycle: ld 16'h0010 and start → qout=0010, state IDLE, busy=0 (ld wins). Same cycle: tick and pause in RUN → paused, no decrement.
- AUTO_RELOAD=1: ld 16'h0002, start, 4 ticks → 0001, 0002 (bout pulse), 0001, 0002 (bout pulse); busy stays 1. Assert rst mid-run → qout=0000 and busy=0 immediately, no bout.

Source files
------------

// File: rtl/count60_down_timer_if.sv
// rtl/count60_down_timer_if.sv - command and status bundle of the mm:ss BCD countdown timer
interface count60_down_timer_if;
    logic        tick;
    logic        ld;
    logic [15:0] ld_val;
    logic        start;
    logic        pause;
    logic [15:0] qout;
    logic        bout;
    logic        busy;
    logic        err;

    modport master (
        output tick, ld, ld_val, start, pause,
        input  qout, bout, busy, err
    );

    modport slave (
        input  tick, ld, ld_val, start, pause,
        output qout, bout, busy, err
    );
endinterface

// File: rtl/count60_down_timer.sv
// rtl/count60_down_timer.sv - loadable mm:ss BCD countdown timer with expiry pulse and optional auto-reload
module count60_down_timer #(
    parameter bit         AUTO_RELOAD = 1'b0,
    parameter logic [7:0] MAX_MIN     = 8'h59
) (
    input logic                  clk,
    input logic                  rst,
    count60_down_timer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [15:0] qout_q;
    logic [15:0] reload_q;
    logic        bout_q;
    logic        busy_q;
    logic        err_q;

    logic [1:0]  nxt_state;
    logic [15:0] nxt_qout;
    logic [15:0] nxt_reload;
    logic        nxt_bout;
    logic        nxt_err;

    logic [15:0] qout_dec;
    logic        ld_ok;

    // A load is accepted only if it is a legal BCD mm:ss not exceeding MAX_MIN minutes.
    assign ld_ok = (bus.ld_val[15:12] <= 4'd9) && (bus.ld_val[11:8] <= 4'd9)
                && (bus.ld_val[7:4]   <= 4'd5) && (bus.ld_val[3:0]  <= 4'd9)
                && (bus.ld_val[15:8]  <= MAX_MIN);

    // One-second BCD decrement with seconds wrapping to 59 and borrowing into minutes.
    always_comb begin
        qout_dec = qout_q;
        if (qout_q[3:0] != 4'd0) begin
            qout_dec[3:0] = qout_q[3:0] - 4'd1;
        end else begin
            qout_dec[3:0] = 4'd9;
            if (qout_q[7:4] != 4'd0) begin
                qout_dec[7:4] = qout_q[7:4] - 4'd1;
            end else begin
                qout_dec[7:4] = 4'd5;
                if (qout_q[11:8] != 4'd0) begin
                    qout_dec[11:8] = qout_q[11:8] - 4'd1;
                end else begin
                    qout_dec[11:8]  = 4'd9;
                    qout_dec[15:12] = qout_q[15:12] - 4'd1;
                end
            end
        end
    end

    // Command decode: only the highest-priority command (ld > start > pause > tick) acts.
    always_comb begin
        nxt_state  = state;
        nxt_qout   = qout_q;
        nxt_reload = reload_q;
        nxt_bout   = 1'b0;
        nxt_err    = 1'b0;
        if (bus.ld) begin
            if (ld_ok) begin
                nxt_qout   = bus.ld_val;
                nxt_reload = bus.ld_val;
                nxt_state  = S_IDLE;
            end else begin
                nxt_err = 1'b1;
            end
        end else if (bus.start) begin
            // Running is never at 0000, so a zero count can only be seen outside RUN.
            if (state != S_RUN) begin
                if (qout_q != 16'h0000) begin
                    nxt_state = S_RUN;
                end else begin
                    nxt_err = 1'b1;
                end
            end
        end else if (bus.pause) begin
            if (state == S_RUN) begin
                nxt_state = S_PAUSE;
            end
        end else if (bus.tick && (state == S_RUN)) begin
            if (qout_q == 16'h0001) begin
                nxt_bout = 1'b1;
                // A zero reload value would re-arm at 0000, so it expires like the one-shot mode.
                if (AUTO_RELOAD && (reload_q != 16'h0000)) begin
                    nxt_qout = reload_q;
                end else begin
                    nxt_qout  = 16'h0000;
                    nxt_state = S_DONE;
                end
            end else begin
                nxt_qout = qout_dec;
            end
        end
    end

    // State and output registers; busy is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            qout_q   <= 16'h0000;
            reload_q <= 16'h0000;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= nxt_state;
            qout_q   <= nxt_qout;
            reload_q <= nxt_reload;
            bout_q   <= nxt_bout;
            busy_q   <= (nxt_state == S_RUN);
            err_q    <= nxt_err;
        end
    end

    assign bus.qout = qout_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_count60_down_timer.sv
// tb/tb_count60_down_timer.sv - self-checking bench for the mm:ss BCD countdown timer
module tb_count60_down_timer;

    logic clk;
    logic rst;

    count60_down_timer_if if0 ();
    count60_down_timer_if if1 ();

    count60_down_timer #(.AUTO_RELOAD(1'b0), .MAX_MIN(8'h59)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    count60_down_timer #(.AUTO_RELOAD(1'b1), .MAX_MIN(8'h59)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        int   secs;
        int   rl;
        int   st;
        logic bout;
        logic busy;
        logic err;
    } mdl_t;

    typedef struct packed {
        logic        tick;
        logic        ld;
        logic [15:0] ld_val;
        logic        start;
        logic        pause;
        logic [15:0] q;
        logic        bout;
        logic        busy;
        logic        err;
    } vec_t;

    mdl_t m0, m1;
    vec_t vt[$];

    function automatic int bcd2s(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] s2bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit valid_ld(input logic [15:0] v);
        if (v[15:12] > 9 || v[11:8] > 9 || v[7:4] > 5 || v[3:0] > 9) return 1'b0;
        return (int'(v[15:12]) * 10 + int'(v[11:8])) <= 59;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m = '0;
        m.st = M_IDLE;
        return m;
    endfunction

    // Reference: count held as plain remaining seconds.
    function automatic mdl_t mstep(input mdl_t mi, input bit ar, input logic t, input logic l,
                                   input logic [15:0] v, input logic s, input logic p);
        mdl_t m;
        m = mi;
        m.bout = 1'b0;
        m.err  = 1'b0;
        if (l) begin
            if (valid_ld(v)) begin
                m.secs = bcd2s(v);
                m.rl   = m.secs;
                m.st   = M_IDLE;
            end else begin
                m.err = 1'b1;
            end
        end else if (s) begin
            if (m.st != M_RUN) begin
                if (m.secs != 0) m.st = M_RUN;
                else             m.err = 1'b1;
            end
        end else if (p) begin
            if (m.st == M_RUN) m.st = M_PAUSE;
        end else if (t && m.st == M_RUN) begin
            m.secs = m.secs - 1;
            if (m.secs == 0) begin
                m.bout = 1'b1;
                if (ar && m.rl != 0) m.secs = m.rl;
                else                 m.st = M_DONE;
            end
        end
        m.busy = (m.st == M_RUN);
        return m;
    endfunction

    function automatic vec_t mk(input logic t, input logic l, input logic [15:0] v, input logic s,
                                input logic p, input logic [15:0] q, input logic b,
                                input logic bu, input logic e);
        return {t, l, v, s, p, q, b, bu, e};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag, input logic [15:0] q, input logic b,
                               input logic bu, input logic e, input mdl_t m);
        check({tag, ".qout"}, q, s2bcd(m.secs));
        check({tag, ".bout"}, {15'd0, b}, {15'd0, m.bout});
        check({tag, ".busy"}, {15'd0, bu}, {15'd0, m.busy});
        check({tag, ".err"}, {15'd0, e}, {15'd0, m.err});
    endtask

    task automatic drive(input logic t, input logic l, input logic [15:0] v, input logic s,
                         input logic p);
        if0.tick = t; if0.ld = l; if0.ld_val = v; if0.start = s; if0.pause = p;
        if1.tick = t; if1.ld = l; if1.ld_val = v; if1.start = s; if1.pause = p;
    endtask

    task automatic step(input logic t, input logic l, input logic [15:0] v, input logic s,
                        input logic p);
        @(negedge clk);
        drive(t, l, v, s, p);
        @(posedge clk);
        #1;
        m0 = mstep(m0, 1'b0, t, l, v, s, p);
        m1 = mstep(m1, 1'b1, t, l, v, s, p);
    endtask

    initial begin
        logic [15:0] rv;
        logic        rt, rl, rs, rp;
        logic [15:0] ar_q [4];
        logic        ar_b [4];

        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        m0 = mreset();
        m1 = mreset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.qout", if0.qout, 16'h0000);
        check("reset.flags", {13'd0, if0.bout, if0.busy, if0.err}, 16'h0000);
        check("reset.qout_ar", if1.qout, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        //          tick  ld    ld_val    start pause  qout      bout  busy  err
        vt.push_back(mk(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0059, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 16'h0560, 1'b0, 1'b0, 16'h0059, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 16'h6000, 1'b0, 1'b0, 16'h0059, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 16'h00a0, 1'b1, 1'b0, 16'h0059, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 16'h5959, 1'b0, 1'b0, 16'h5959, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5959, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h5958, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));

        foreach (vt[i]) begin
            step(vt[i].tick, vt[i].ld, vt[i].ld_val, vt[i].start, vt[i].pause);
            check($sformatf("vec%0d.qout", i), if0.qout, vt[i].q);
            check($sformatf("vec%0d.flags", i), {13'd0, if0.bout, if0.busy, if0.err},
                  {13'd0, vt[i].bout, vt[i].busy, vt[i].err});
            check_model($sformatf("vec%0d.ar", i), if1.qout, if1.bout, if1.busy, if1.err, m1);
        end

        // Auto-reload sequence on the reloading instance.
        ar_q[0] = 16'h0001; ar_b[0] = 1'b0;
        ar_q[1] = 16'h0002; ar_b[1] = 1'b1;
        ar_q[2] = 16'h0001; ar_b[2] = 1'b0;
        ar_q[3] = 16'h0002; ar_b[3] = 1'b1;
        step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("ar.start.busy", {15'd0, if1.busy}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            check($sformatf("ar.tick%0d.qout", i), if1.qout, ar_q[i]);
            check($sformatf("ar.tick%0d.bout", i), {15'd0, if1.bout}, {15'd0, ar_b[i]});
            check($sformatf("ar.tick%0d.busy", i), {15'd0, if1.busy}, 16'd1);
            check_model($sformatf("ar.tick%0d.oneshot", i), if0.qout, if0.bout, if0.busy, if0.err, m0);
        end
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("ar.pre_rst.qout", if1.qout, 16'h0001);

        // Asynchronous reset mid-run, away from any clock edge.
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid.qout", if1.qout, 16'h0000);
        check("rst_mid.flags", {13'd0, if1.bout, if1.busy, if1.err}, 16'h0000);
        m0 = mreset();
        m1 = mreset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            check($sformatf("post_rst%0d.qout", i), if1.qout, 16'h0000);
            check($sformatf("post_rst%0d.flags", i), {13'd0, if1.bout, if1.busy, if1.err}, 16'h0000);
        end

        // Randomized commands against the seconds-based reference model.
        for (int i = 0; i < 800; i++) begin
            rl = ($urandom_range(99) < 6);
            rs = ($urandom_range(99) < 12);
            rp = ($urandom_range(99) < 5);
            rt = ($urandom_range(99) < 45);
            case ($urandom_range(3))
                0, 1:    rv = s2bcd(int'($urandom_range(8)));
                2:       rv = s2bcd(int'($urandom_range(59)) * 60 + int'($urandom_range(59)));
                default: rv = 16'($urandom);
            endcase
            step(rt, rl, rv, rs, rp);
            check_model($sformatf("rnd%0d.d0", i), if0.qout, if0.bout, if0.busy, if0.err, m0);
            check_model($sformatf("rnd%0d.d1", i), if1.qout, if1.bout, if1.busy, if1.err, m1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
